// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - command-driven JTAG master: walks the TAP FSM, shifts IR/DR, returns captured TDO
module jtag_master #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6,
    parameter int CLK_DIV    = 4
) (
    input  logic                  system_clk,
    input  logic                  reset_bar,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  TCK,
    output logic                  TMS,
    output logic                  TDI,
    input  logic                  TDO
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);
    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_RUN   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, RESET_SEQ, NAV_IN, SHIFT, NAV_OUT, RUNTEST, DONE
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   step;
    logic [1:0]             op_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  cap_q;
    logic                   synced;
    logic                   in_period;
    logic                   tck_high;
    logic [DIV_W-1:0]       div_cnt;

    logic                   last;
    state_t                 nxt_state;
    logic [LEN_WIDTH-1:0]   nxt_step;
    state_t                 launch_state;
    logic [LEN_WIDTH-1:0]   launch_step;
    logic                   launch_tms;
    logic                   launch_shift;
    logic                   launch_active;
    logic                   period_end;
    logic                   do_launch;
    logic [LEN_WIDTH-1:0]   len_c;

    function automatic state_t dispatch(input logic [1:0] op, input logic [LEN_WIDTH-1:0] len);
        if (op == OP_RUN)
            return (len == '0) ? DONE : RUNTEST;
        return NAV_IN;
    endfunction

    // TMS for a given TCK; len=0 shifts take the extra Capture->Exit1 TCK at the start of NAV_OUT
    function automatic logic tms_of(input state_t st, input logic [LEN_WIDTH-1:0] stp,
                                    input logic [1:0] op, input logic [LEN_WIDTH-1:0] len);
        case (st)
            RESET_SEQ: return stp != LEN_WIDTH'(5);
            NAV_IN:    return (op == OP_IR) ? (stp != LEN_WIDTH'(2)) : (stp == '0);
            SHIFT:     return (stp != '0) && (stp == len);
            NAV_OUT:   return (len == '0) ? (stp != LEN_WIDTH'(2)) : (stp == '0);
            default:   return 1'b0;
        endcase
    endfunction

    always_comb begin
        len_c     = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        last      = 1'b0;
        nxt_state = state;
        case (state)
            RESET_SEQ: begin
                last      = (step == LEN_WIDTH'(5));
                nxt_state = !last ? RESET_SEQ : (op_q == OP_RESET) ? DONE : dispatch(op_q, len_q);
            end
            NAV_IN: begin
                last      = (step == ((op_q == OP_IR) ? LEN_WIDTH'(2) : ONE));
                nxt_state = !last ? NAV_IN : (len_q == '0) ? NAV_OUT : SHIFT;
            end
            SHIFT: begin
                last      = (step == len_q);
                nxt_state = last ? NAV_OUT : SHIFT;
            end
            NAV_OUT: begin
                last      = (step == ((len_q == '0) ? LEN_WIDTH'(2) : ONE));
                nxt_state = last ? DONE : NAV_OUT;
            end
            RUNTEST: begin
                last      = (step == len_q - ONE);
                nxt_state = last ? DONE : RUNTEST;
            end
            default: ;
        endcase
        nxt_step      = last ? '0 : step + ONE;
        period_end    = in_period && tck_high && (div_cnt == DIV_LAST);
        launch_state  = in_period ? nxt_state : state;
        launch_step   = in_period ? nxt_step : step;
        launch_active = (launch_state != IDLE) && (launch_state != DONE);
        launch_tms    = tms_of(launch_state, launch_step, op_q, len_q);
        launch_shift  = (launch_state == SHIFT) && (launch_step != '0);
        do_launch     = (!in_period || period_end) && launch_active;
    end

    always_ff @(posedge system_clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state     <= IDLE;
            step      <= '0;
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            synced    <= 1'b0;
            in_period <= 1'b0;
            tck_high  <= 1'b0;
            div_cnt   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        op_q      <= cmd_op;
                        len_q     <= len_c;
                        data_q    <= cmd_data;
                        cap_q     <= '0;
                        step      <= '0;
                        in_period <= 1'b0;
                        state     <= (cmd_op == OP_RESET || !synced) ? RESET_SEQ
                                                                      : dispatch(cmd_op, len_c);
                    end else begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b1;
                    // captured bits sit at the top of cap_q; shifting right aligns them and clears bits >= len
                    rsp_data  <= (op_q == OP_IR || op_q == OP_DR) ? (cap_q >> (LEN_MAX - len_q)) : '0;
                    state     <= IDLE;
                end
                default: begin
                    if (period_end && state == RESET_SEQ && last)
                        synced <= 1'b1;
                    if (do_launch) begin
                        TCK       <= 1'b0;
                        TMS       <= launch_tms;
                        state     <= launch_state;
                        step      <= launch_step;
                        in_period <= 1'b1;
                        tck_high  <= 1'b0;
                        div_cnt   <= '0;
                        if (launch_shift) begin
                            TDI    <= data_q[0];
                            data_q <= data_q >> 1;
                        end else begin
                            TDI <= 1'b1;
                        end
                    end else if (period_end) begin
                        TCK       <= 1'b0;
                        TDI       <= 1'b1;
                        in_period <= 1'b0;
                        tck_high  <= 1'b0;
                        div_cnt   <= '0;
                        state     <= nxt_state;
                        step      <= nxt_step;
                    end else if (in_period) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt  <= '0;
                            TCK      <= 1'b1;
                            tck_high <= 1'b1;
                            if (state == SHIFT && step != '0)
                                cap_q <= {TDO, cap_q[DATA_WIDTH-1:1]};
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - scoreboard bench for jtag_master against a behavioural TAP model
`timescale 1ns/1ps
module tb_jtag_master;

    logic        system_clk = 1'b0;
    logic        reset_bar  = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op     = 2'b00;
    logic [5:0]  cmd_len    = 6'd0;
    logic [31:0] cmd_data   = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        TCK, TMS, TDI;
    logic        tdo = 1'b0;

    always #5 system_clk = ~system_clk;

    jtag_master dut (
        .system_clk(system_clk), .reset_bar(reset_bar),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(tdo)
    );

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_t;

    localparam logic [31:0] IDCODE = 32'h1234_5677;

    tap_t        tap    = TLR;
    logic [2:0]  ir     = 3'b010;
    logic [2:0]  ir_sr  = 3'b000;
    logic [31:0] dr_sr  = 32'h0;
    logic        byp    = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PADR;
            PADR:  return t ? EX2DR : PADR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PAIR;
            PAIR:  return t ? EX2IR : PAIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    // target TAP: IR 111 selects 1-bit BYPASS, anything else a 32-bit IDCODE register
    always @(posedge TCK) begin
        case (tap)
            TLR:   ir <= 3'b010;
            CAPIR: ir_sr <= 3'b001;
            SHIR:  ir_sr <= {TDI, ir_sr[2:1]};
            UPIR:  ir <= ir_sr;
            CAPDR: begin byp <= 1'b0; dr_sr <= IDCODE; end
            SHDR:  if (ir == 3'b111) byp <= TDI; else dr_sr <= {TDI, dr_sr[31:1]};
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    always @(negedge TCK) begin
        if (tap == SHIR)      tdo <= ir_sr[0];
        else if (tap == SHDR) tdo <= (ir == 3'b111) ? byp : dr_sr[0];
    end

    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];
    int   rise_total = 0;
    logic hi_tms = 1'b1, hi_tdi = 1'b1;
    int   viol = 0;

    always @(posedge TCK) begin
        tms_hist[rise_total] <= TMS;
        tdi_hist[rise_total] <= TDI;
        hi_tms     <= TMS;
        hi_tdi     <= TDI;
        rise_total <= rise_total + 1;
    end

    always @(negedge system_clk)
        if (reset_bar && TCK && (TMS !== hi_tms || TDI !== hi_tdi)) viol <= viol + 1;

    typedef struct {
        logic [31:0] data;
        int          tcks;
        int          nlog;
        logic [63:0] tms;
        logic [63:0] tdi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   rise_base = 0;
    int   rsp_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input int t, input int n,
                                input logic [63:0] tms, input logic [63:0] tdi);
        exp_t e;
        e.data = d; e.tcks = t; e.nlog = n; e.tms = tms; e.tdi = tdi;
        return e;
    endfunction

    initial forever begin
        @(negedge system_clk);
        if (!reset_bar) begin
            rise_base = rise_total;
        end else if (rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", rsp_data, 64'hDEAD);
            end else begin
                exp_t e;
                logic [63:0] tv, dv;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("tck_count", rise_total - rise_base, e.tcks);
                chk("tap_in_run_idle", tap, RTI);
                if (e.nlog > 0) begin
                    tv = '0; dv = '0;
                    for (int i = 0; i < e.nlog; i++) begin
                        tv[i] = tms_hist[rise_base + i];
                        dv[i] = tdi_hist[rise_base + i];
                    end
                    chk("tms_sequence", tv, e.tms);
                    chk("tdi_sequence", dv, e.tdi);
                end
            end
            rise_base = rise_total;
        end
    end

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int n = 0;
        @(negedge system_clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        while (!cmd_ready && n < 200) begin @(negedge system_clk); n++; end
        if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
        @(posedge system_clk);
        @(negedge system_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge system_clk); n++; end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(negedge system_clk);
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data, input exp_t e);
        exp_q.push_back(e);
        send(op, len, data);
        wait_idle();
    endtask

    initial begin
        int n, lat, seen;
        repeat (3) @(negedge system_clk);
        chk("reset_tck", TCK, 0);
        chk("reset_tms", TMS, 1);
        chk("reset_tdi", TDI, 1);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        reset_bar = 1'b1;
        repeat (2) @(negedge system_clk);

        run(2'b00, 6'd0,  32'h0,         mk(32'h0, 6, 6, 64'h1F, 64'h3F));
        run(2'b01, 6'd3,  32'h5,         mk(32'h1, 9, 9, 64'hC3, 64'h1DF));
        chk("ir_loaded_101", ir, 3'b101);
        run(2'b01, 6'd3,  32'h7,         mk(32'h1, 9, 0, 0, 0));
        chk("ir_loaded_bypass", ir, 3'b111);
        run(2'b10, 6'd32, 32'hA5A5_1234, mk(32'h4B4A_2468, 37, 0, 0, 0));
        run(2'b10, 6'd0,  32'hFFFF_FFFF, mk(32'h0, 5, 5, 64'h0D, 64'h1F));
        run(2'b10, 6'd40, 32'h8000_0001, mk(32'h0000_0002, 37, 0, 0, 0));

        exp_q.push_back(mk(32'h0, 0, 0, 0, 0));
        send(2'b11, 6'd0, 32'h0);
        lat = 0;
        while (!rsp_valid && lat < 10) begin @(negedge system_clk); lat++; end
        chk("runidle0_latency_ok", (lat >= 1 && lat <= 2), 1);
        wait_idle();

        run(2'b11, 6'd4,  32'h0,         mk(32'h0, 4, 4, 64'h0, 64'hF));
        run(2'b01, 6'd3,  32'h2,         mk(32'h1, 9, 0, 0, 0));
        run(2'b10, 6'd16, 32'h0,         mk(32'h0000_5677, 21, 0, 0, 0));

        seen = rsp_count;
        send(2'b10, 6'd32, 32'hFFFF_0000);
        n = 0;
        while ((rise_total - rise_base) < 14 && n < 2000) begin @(negedge system_clk); n++; end
        chk("abort_reached_bit10", rise_total - rise_base, 14);
        #2 reset_bar = 1'b0;
        #1;
        chk("abort_tck", TCK, 0);
        chk("abort_tms", TMS, 1);
        chk("abort_tdi", TDI, 1);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge system_clk);
        reset_bar = 1'b1;
        repeat (20) @(negedge system_clk);
        chk("abort_no_rsp_valid", rsp_count, seen);

        run(2'b10, 6'd8,  32'h0000_00FF, mk(32'h77, 19, 19, 64'h3005F, 64'h7FFFF));

        chk("tms_tdi_stable_while_tck_high", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
